// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 key-search controller and its engines.
// The owner decode maps each controller state to the engine holding S-memory.
package rc4_pkg;

    localparam int KEY_W  = 24;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_GO,
        S_INIT_WAIT,
        S_SHUF_GO,
        S_SHUF_WAIT,
        S_DEC_GO,
        S_DEC_WAIT,
        S_NEXT_KEY,
        S_FOUND,
        S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_SHUF,
        OWN_DEC
    } owner_t;

    function automatic owner_t owner_of(input state_t s);
        owner_t o;
        o = OWN_NONE;
        case (s)
            S_INIT_GO, S_INIT_WAIT: o = OWN_INIT;
            S_SHUF_GO, S_SHUF_WAIT: o = OWN_SHUF;
            S_DEC_GO,  S_DEC_WAIT:  o = OWN_DEC;
            default:                o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rc4_mem_mux.sv
// Combinational S-memory port mux; only the owning engine reaches mem_*.
// With no owner the port is parked at zero so stray writes cannot land.
module rc4_mem_mux
    import rc4_pkg::*;
(
    input  owner_t              owner,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_data,
    input  logic                init_wren,
    input  logic [ADDR_W-1:0]   shuf_addr,
    input  logic [DATA_W-1:0]   shuf_data,
    input  logic                shuf_wren,
    input  logic [ADDR_W-1:0]   dec_addr,
    input  logic [DATA_W-1:0]   dec_data,
    input  logic                dec_wren,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_wren
);

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        case (owner)
            OWN_INIT: begin
                mem_address = init_addr;
                mem_data    = init_data;
                mem_wren    = init_wren;
            end
            OWN_SHUF: begin
                mem_address = shuf_addr;
                mem_data    = shuf_data;
                mem_wren    = shuf_wren;
            end
            OWN_DEC: begin
                mem_address = dec_addr;
                mem_data    = dec_data;
                mem_wren    = dec_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search sequencer: init, shuffle, decrypt per key,
// stepping keys from KEY_MIN to KEY_MAX with a per-wait watchdog.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_MIN = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF,
    parameter int               TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                init_start,
    output logic                shuf_start,
    output logic                dec_start,
    input  logic                init_finish,
    input  logic                shuf_finish,
    input  logic                dec_finish,
    input  logic                dec_key_ok,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_data,
    input  logic                init_wren,
    input  logic [ADDR_W-1:0]   shuf_addr,
    input  logic [DATA_W-1:0]   shuf_data,
    input  logic                shuf_wren,
    input  logic [ADDR_W-1:0]   dec_addr,
    input  logic [DATA_W-1:0]   dec_data,
    input  logic                dec_wren,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_wren,
    output logic [KEY_W-1:0]    secret_key,
    output logic                done,
    output logic                found,
    output logic                err
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wd;
    logic        wd_hit;
    owner_t      owner;

    assign wd_hit     = (wd == WD_LAST);
    assign init_start = (state == S_INIT_GO);
    assign shuf_start = (state == S_SHUF_GO);
    assign dec_start  = (state == S_DEC_GO);
    assign owner      = owner_of(state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            secret_key <= KEY_MIN;
            wd         <= '0;
            done       <= 1'b0;
            found      <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FOUND, S_FAIL: begin
                    if (start) begin
                        secret_key <= KEY_MIN;
                        done       <= 1'b0;
                        found      <= 1'b0;
                        err        <= 1'b0;
                        state      <= S_INIT_GO;
                    end
                end
                // each GO cycle arms the watchdog for the WAIT that follows
                S_INIT_GO: begin
                    wd    <= '0;
                    state <= S_INIT_WAIT;
                end
                S_SHUF_GO: begin
                    wd    <= '0;
                    state <= S_SHUF_WAIT;
                end
                S_DEC_GO: begin
                    wd    <= '0;
                    state <= S_DEC_WAIT;
                end
                S_INIT_WAIT: begin
                    if (init_finish) begin
                        state <= S_SHUF_GO;
                    end else if (wd_hit) begin
                        state <= S_FAIL;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                S_SHUF_WAIT: begin
                    if (shuf_finish) begin
                        state <= S_DEC_GO;
                    end else if (wd_hit) begin
                        state <= S_FAIL;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                S_DEC_WAIT: begin
                    if (dec_finish) begin
                        if (dec_key_ok) begin
                            state <= S_FOUND;
                            done  <= 1'b1;
                            found <= 1'b1;
                        end else if (secret_key == KEY_MAX) begin
                            state <= S_FAIL;
                            done  <= 1'b1;
                        end else begin
                            state <= S_NEXT_KEY;
                        end
                    end else if (wd_hit) begin
                        state <= S_FAIL;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                S_NEXT_KEY: begin
                    secret_key <= secret_key + 1'b1;
                    state      <= S_INIT_GO;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    rc4_mem_mux u_mem_mux (
        .owner       (owner),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .init_wren   (init_wren),
        .shuf_addr   (shuf_addr),
        .shuf_data   (shuf_data),
        .shuf_wren   (shuf_wren),
        .dec_addr    (dec_addr),
        .dec_data    (dec_data),
        .dec_wren    (dec_wren),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren)
    );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl: two instances with engine models,
// expected search outcomes queued at start and checked when done rises.
module tb_rc4_key_search_ctrl;

    typedef struct {
        logic        fnd;
        logic        er;
        logic [23:0] key;
        int          inits;
    } exp_t;

    exp_t sb[$];

    logic        clk;
    logic        rst[2];
    logic        start[2];
    logic        init_start[2];
    logic        shuf_start[2];
    logic        dec_start[2];
    logic        init_finish[2];
    logic        shuf_finish[2];
    logic        dec_finish[2];
    logic        dec_key_ok[2];
    logic [7:0]  init_addr[2];
    logic [7:0]  init_data[2];
    logic        init_wren[2];
    logic [7:0]  shuf_addr[2];
    logic [7:0]  shuf_data[2];
    logic        shuf_wren[2];
    logic [7:0]  dec_addr[2];
    logic [7:0]  dec_data[2];
    logic        dec_wren[2];
    logic [7:0]  mem_address[2];
    logic [7:0]  mem_data[2];
    logic        mem_wren[2];
    logic [23:0] secret_key[2];
    logic        done[2];
    logic        found[2];
    logic        err[2];

    logic        shuf_en[2];
    logic        ok_en[2];
    logic [23:0] ok_key[2];
    int          icnt[2];
    int          scnt[2];
    int          dcnt[2];
    int          n_init[2];
    int          n_dec[2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rc4_key_search_ctrl #(
        .KEY_MIN (24'h000000),
        .KEY_MAX (24'h000003),
        .TIMEOUT (16)
    ) dut_a (
        .clk         (clk),
        .reset       (rst[0]),
        .start       (start[0]),
        .init_start  (init_start[0]),
        .shuf_start  (shuf_start[0]),
        .dec_start   (dec_start[0]),
        .init_finish (init_finish[0]),
        .shuf_finish (shuf_finish[0]),
        .dec_finish  (dec_finish[0]),
        .dec_key_ok  (dec_key_ok[0]),
        .init_addr   (init_addr[0]),
        .init_data   (init_data[0]),
        .init_wren   (init_wren[0]),
        .shuf_addr   (shuf_addr[0]),
        .shuf_data   (shuf_data[0]),
        .shuf_wren   (shuf_wren[0]),
        .dec_addr    (dec_addr[0]),
        .dec_data    (dec_data[0]),
        .dec_wren    (dec_wren[0]),
        .mem_address (mem_address[0]),
        .mem_data    (mem_data[0]),
        .mem_wren    (mem_wren[0]),
        .secret_key  (secret_key[0]),
        .done        (done[0]),
        .found       (found[0]),
        .err         (err[0])
    );

    rc4_key_search_ctrl #(
        .KEY_MIN (24'h000004),
        .KEY_MAX (24'h000007),
        .TIMEOUT (64)
    ) dut_b (
        .clk         (clk),
        .reset       (rst[1]),
        .start       (start[1]),
        .init_start  (init_start[1]),
        .shuf_start  (shuf_start[1]),
        .dec_start   (dec_start[1]),
        .init_finish (init_finish[1]),
        .shuf_finish (shuf_finish[1]),
        .dec_finish  (dec_finish[1]),
        .dec_key_ok  (dec_key_ok[1]),
        .init_addr   (init_addr[1]),
        .init_data   (init_data[1]),
        .init_wren   (init_wren[1]),
        .shuf_addr   (shuf_addr[1]),
        .shuf_data   (shuf_data[1]),
        .shuf_wren   (shuf_wren[1]),
        .dec_addr    (dec_addr[1]),
        .dec_data    (dec_data[1]),
        .dec_wren    (dec_wren[1]),
        .mem_address (mem_address[1]),
        .mem_data    (mem_data[1]),
        .mem_wren    (mem_wren[1]),
        .secret_key  (secret_key[1]),
        .done        (done[1]),
        .found       (found[1]),
        .err         (err[1])
    );

    // engines answer 5 cycles after seeing their start pulse
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            init_finish[i] <= 1'b0;
            shuf_finish[i] <= 1'b0;
            dec_finish[i]  <= 1'b0;
            if (init_start[i] === 1'b1) n_init[i] <= n_init[i] + 1;
            if (dec_start[i] === 1'b1) n_dec[i] <= n_dec[i] + 1;
            if (init_start[i] === 1'b1) icnt[i] <= 5;
            else if (icnt[i] != 0) begin
                icnt[i] <= icnt[i] - 1;
                if (icnt[i] == 1) init_finish[i] <= 1'b1;
            end
            if (shuf_start[i] === 1'b1) scnt[i] <= 5;
            else if (scnt[i] != 0) begin
                scnt[i] <= scnt[i] - 1;
                if (scnt[i] == 1 && shuf_en[i]) shuf_finish[i] <= 1'b1;
            end
            if (dec_start[i] === 1'b1) dcnt[i] <= 5;
            else if (dcnt[i] != 0) begin
                dcnt[i] <= dcnt[i] - 1;
                if (dcnt[i] == 1) begin
                    dec_finish[i] <= 1'b1;
                    dec_key_ok[i] <= ok_en[i] && (secret_key[i] == ok_key[i]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int base);
        int   n;
        exp_t e;
        n = 0;
        while (done[i] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done[i]}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty_at_done", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("found", {31'd0, found[i]}, {31'd0, e.fnd});
            chk("err", {31'd0, err[i]}, {31'd0, e.er});
            chk("key", {8'd0, secret_key[i]}, {8'd0, e.key});
            chk("inits", n_init[i] - base, e.inits);
        end
    endtask

    initial begin
        int base;
        int n;
        int nd;
        int ni;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0;
            start[i] = 1'b0;
            init_addr[i] = 8'h00; init_data[i] = 8'h00; init_wren[i] = 1'b0;
            shuf_addr[i] = 8'h00; shuf_data[i] = 8'h00; shuf_wren[i] = 1'b0;
            dec_addr[i] = 8'h00; dec_data[i] = 8'h00; dec_wren[i] = 1'b0;
            shuf_en[i] = 1'b1;
            ok_en[i] = 1'b0;
            ok_key[i] = 24'h0;
            icnt[i] = 0; scnt[i] = 0; dcnt[i] = 0;
            n_init[i] = 0; n_dec[i] = 0;
            init_finish[i] = 1'b0; shuf_finish[i] = 1'b0;
            dec_finish[i] = 1'b0; dec_key_ok[i] = 1'b0;
        end
        ok_en[0] = 1'b1;
        ok_key[0] = 24'h000002;
        init_wren[0] = 1'b1; shuf_wren[0] = 1'b1; dec_wren[0] = 1'b1;
        init_addr[0] = 8'h33; init_data[0] = 8'h44;
        #1;
        chk("rst_key", {8'd0, secret_key[0]}, 32'd0);
        chk("rst_done", {31'd0, done[0]}, 32'd0);
        chk("rst_found", {31'd0, found[0]}, 32'd0);
        chk("rst_err", {31'd0, err[0]}, 32'd0);
        chk("rst_init_start", {31'd0, init_start[0]}, 32'd0);
        chk("idle_mem_addr", {24'd0, mem_address[0]}, 32'd0);
        chk("idle_mem_data", {24'd0, mem_data[0]}, 32'd0);
        chk("idle_mem_wren", {31'd0, mem_wren[0]}, 32'd0);
        init_wren[0] = 1'b0; shuf_wren[0] = 1'b0; dec_wren[0] = 1'b0;
        init_addr[0] = 8'h00; init_data[0] = 8'h00;
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_start_after_reset", n_init[0], 0);

        // key 2 decrypts: three keys tried
        base = n_init[0];
        sb.push_back('{1'b1, 1'b0, 24'h000002, 3});
        pulse_start(0);
        wait_done(0, base);

        // restart from FOUND with no valid key: exhaust 0..3
        ok_en[0] = 1'b0;
        @(negedge clk);
        base = n_init[0];
        sb.push_back('{1'b0, 1'b0, 24'h000003, 4});
        pulse_start(0);
        chk("restart_init_start", {31'd0, init_start[0]}, 32'd1);
        chk("restart_done", {31'd0, done[0]}, 32'd0);
        chk("restart_found", {31'd0, found[0]}, 32'd0);
        chk("restart_key", {8'd0, secret_key[0]}, 32'd0);
        @(negedge clk);
        shuf_wren[0] = 1'b1; shuf_addr[0] = 8'hAA;
        init_addr[0] = 8'h11; init_wren[0] = 1'b0; init_data[0] = 8'h5A;
        #1;
        chk("mux_addr", {24'd0, mem_address[0]}, 32'h11);
        chk("mux_wren_blocked", {31'd0, mem_wren[0]}, 32'd0);
        chk("mux_data", {24'd0, mem_data[0]}, 32'h5A);
        init_wren[0] = 1'b1;
        #1;
        chk("mux_wren_owner", {31'd0, mem_wren[0]}, 32'd1);
        shuf_wren[0] = 1'b0; shuf_addr[0] = 8'h00;
        init_addr[0] = 8'h00; init_wren[0] = 1'b0; init_data[0] = 8'h00;
        wait_done(0, base);

        // shuffle engine never finishes: watchdog expiry
        shuf_en[0] = 1'b0;
        base = n_init[0];
        sb.push_back('{1'b0, 1'b1, 24'h000000, 1});
        pulse_start(0);
        n = 0;
        while (shuf_start[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("shuf_start_seen", {31'd0, shuf_start[0]}, 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 15) chk("wd_not_yet", {31'd0, done[0]}, 32'd0);
            if (k == 16) chk("wd_expire_done", {31'd0, done[0]}, 32'd1);
            if (k == 16) chk("wd_expire_err", {31'd0, err[0]}, 32'd1);
        end
        wait_done(0, base);
        shuf_en[0] = 1'b1;

        // async reset while decrypting key 5 on the second instance
        pulse_start(1);
        n = 0;
        while (!(dec_start[1] === 1'b1 && secret_key[1] == 24'h5) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("dec_key5", {8'd0, secret_key[1]}, 32'h5);
        @(negedge clk);
        dec_wren[1] = 1'b1; dec_addr[1] = 8'h77;
        init_addr[1] = 8'h11; init_wren[1] = 1'b1;
        #1;
        chk("dec_mux_addr", {24'd0, mem_address[1]}, 32'h77);
        chk("dec_mux_wren", {31'd0, mem_wren[1]}, 32'd1);
        #1;
        rst[1] = 1'b0;
        #1;
        chk("async_key", {8'd0, secret_key[1]}, 32'h4);
        chk("async_done", {31'd0, done[1]}, 32'd0);
        chk("async_dec_start", {31'd0, dec_start[1]}, 32'd0);
        chk("async_mem_wren", {31'd0, mem_wren[1]}, 32'd0);
        chk("async_mem_addr", {24'd0, mem_address[1]}, 32'd0);
        nd = n_dec[1];
        ni = n_init[1];
        @(negedge clk);
        rst[1] = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_dec_after_reset", n_dec[1], nd);
        chk("no_init_after_reset", n_init[1], ni);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
